// File: rtl/lut8_cfg_loader.sv
// Configurable 1-bit lookup table: loaded as CFG_W-bit beats over a valid/ready
// stream, then read with single-cycle latency.
module lut8_cfg_loader #(
  parameter int IN_BITS = 8,
  parameter int CFG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic               cfg_done,
  output logic               cfg_err,
  output logic               loaded,
  input  logic [IN_BITS-1:0] M0,
  input  logic               in_valid,
  output logic               M1,
  output logic               out_valid
);

  localparam int DEPTH = 1 << IN_BITS;
  localparam int BEATS = DEPTH / CFG_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DEPTH-1:0]   table_q, table_d;
  logic               loaded_q, loaded_d;
  logic               cfg_done_q, cfg_done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               m1_q, m1_d;
  logic               out_valid_q, out_valid_d;

  logic               beat_accept;
  logic               last_beat;
  logic               lookup_accept;
  logic [IN_BITS-1:0] wr_base;

  assign cfg_ready     = (state_q == LOAD);
  // A start request takes priority over a beat offered in the same cycle.
  assign beat_accept   = cfg_ready && cfg_valid && !cfg_start;
  assign last_beat     = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign lookup_accept = (state_q == READY) && in_valid;
  assign wr_base       = IN_BITS'(beat_cnt_q) * IN_BITS'(CFG_W);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    table_d     = table_q;
    loaded_d    = loaded_q;
    cfg_done_d  = 1'b0;
    cfg_err_d   = 1'b0;
    m1_d        = m1_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE, READY: begin
        if (cfg_start) begin
          state_d    = LOAD;
          beat_cnt_d = '0;
          loaded_d   = 1'b0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          // Restart keeps already-written entries; the new image overwrites them.
          beat_cnt_d = '0;
          cfg_err_d  = 1'b1;
        end else if (beat_accept) begin
          table_d[wr_base +: CFG_W] = cfg_data;
          if (last_beat) begin
            state_d    = READY;
            beat_cnt_d = '0;
            loaded_d   = 1'b1;
            cfg_done_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reads the pre-write table, so a lookup issued alongside cfg_start sees the old image.
    if (lookup_accept) begin
      m1_d        = table_q[M0];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      // NOTE: the table is cleared on reset so a discarded partial image can
      // never be read back; this costs a reset net on every storage bit.
      table_q     <= '0;
      loaded_q    <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      m1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      table_q     <= table_d;
      loaded_q    <= loaded_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
      m1_q        <= m1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign loaded    = loaded_q;
  assign M1        = m1_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lut8_cfg_loader.sv
// Self-checking bench for lut8_cfg_loader: a cycle model predicts the control
// pulses and a scoreboard queue carries expected lookup results.
module tb_lut8_cfg_loader;

  localparam int IN_BITS = 8;
  localparam int CFG_W   = 8;
  localparam int DEPTH   = 256;
  localparam int BEATS   = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [7:0]   cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         cfg_done;
  logic         cfg_err;
  logic         loaded;
  logic [7:0]   m0;
  logic         in_valid;
  logic         m1;
  logic         out_valid;

  lut8_cfg_loader #(.IN_BITS(IN_BITS), .CFG_W(CFG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .loaded    (loaded),
    .M0        (m0),
    .in_valid  (in_valid),
    .M1        (m1),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: 0 = IDLE, 1 = LOAD, 2 = READY
  bit model_tbl [DEPTH];
  int m_state   = 0;
  int m_cnt     = 0;
  bit m_loaded  = 1'b0;
  bit exp_m1    = 1'b0;
  bit exp_q [$];
  int done_seen = 0;
  int err_seen  = 0;

  // One clock cycle: predict, advance past the edge, compare every output.
  task automatic step();
    bit pushed;
    bit exp_done;
    bit exp_err;
    tests_run++;
    if (cfg_ready !== (m_state == 1)) begin
      tests_failed++;
      $display("FAIL cfg_ready: got %b expected %b", cfg_ready, (m_state == 1));
    end
    pushed   = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (!rst && m_state == 2 && in_valid) begin
      exp_q.push_back(model_tbl[m0]);
      pushed = 1'b1;
    end
    if (rst) begin
      m_state  = 0;
      m_cnt    = 0;
      m_loaded = 1'b0;
      exp_m1   = 1'b0;
      exp_q.delete();
      foreach (model_tbl[i]) model_tbl[i] = 1'b0;
    end else if (cfg_start) begin
      if (m_state == 1) exp_err = 1'b1;
      m_state  = 1;
      m_cnt    = 0;
      m_loaded = 1'b0;
    end else if (m_state == 1 && cfg_valid) begin
      for (int i = 0; i < CFG_W; i++) model_tbl[m_cnt * CFG_W + i] = cfg_data[i];
      if (m_cnt == BEATS - 1) begin
        m_state  = 2;
        m_loaded = 1'b1;
        exp_done = 1'b1;
        m_cnt    = 0;
      end else begin
        m_cnt++;
      end
    end

    @(posedge clk);
    #1;

    if (pushed) exp_m1 = exp_q.pop_front();
    tests_run += 5;
    if (cfg_done !== exp_done) begin
      tests_failed++;
      $display("FAIL cfg_done: got %b expected %b", cfg_done, exp_done);
    end
    if (cfg_err !== exp_err) begin
      tests_failed++;
      $display("FAIL cfg_err: got %b expected %b", cfg_err, exp_err);
    end
    if (loaded !== m_loaded) begin
      tests_failed++;
      $display("FAIL loaded: got %b expected %b", loaded, m_loaded);
    end
    if (out_valid !== pushed) begin
      tests_failed++;
      $display("FAIL out_valid: got %b expected %b", out_valid, pushed);
    end
    if (m1 !== exp_m1) begin
      tests_failed++;
      $display("FAIL m1: got %b expected %b", m1, exp_m1);
    end
    if (cfg_done === 1'b1) done_seen++;
    if (cfg_err === 1'b1) err_seen++;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic send_beats(input logic [7:0] pat, input int n, input bit stall);
    for (int k = 0; k < n; k++) begin
      if (stall) begin
        cfg_valid = 1'b0;
        step();
      end
      cfg_valid = 1'b1;
      cfg_data  = pat;
      step();
    end
    cfg_valid = 1'b0;
  endtask

  // Back-to-back lookups of every address against a uniformly repeated beat.
  task automatic sweep(input logic [7:0] pat);
    int bad;
    bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      m0 = 8'(i);
      step();
      if (out_valid !== 1'b1 || m1 !== pat[i % 8]) bad++;
    end
    in_valid = 1'b0;
    step();
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL sweep_%h: %0d bad lookups, required 0", pat, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    done_seen = 0;
    err_seen  = 0;
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (done_seen != 0 || err_seen != 0 || loaded !== 1'b0 || m1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_quiet: done=%0d err=%0d loaded=%b m1=%b, required 0 0 0 0",
               done_seen, err_seen, loaded, m1);
    end
  endtask

  task automatic test_idle_gating();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0 = 8'(i * 60);
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_gating: out_valid=%b required 0", out_valid);
    end
    // Beats offered outside LOAD must neither load nor flag anything.
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    step();
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_full_load();
    logic [7:0] addr [4];
    logic       want [4];
    addr = '{8'd0, 8'd1, 8'd2, 8'd255};
    want = '{1'b1, 1'b0, 1'b1, 1'b1};
    done_seen = 0;
    err_seen  = 0;
    pulse_start();
    send_beats(8'hA5, BEATS, 1'b0);
    tests_run++;
    if (done_seen != 1 || err_seen != 0 || loaded !== 1'b1 || cfg_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_load: done=%0d err=%0d loaded=%b ready=%b, required 1 0 1 0",
               done_seen, err_seen, loaded, cfg_ready);
    end
    // cfg_valid in READY must leave the image untouched.
    cfg_valid = 1'b1;
    cfg_data  = 8'h00;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      m0 = addr[i];
      step();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || m1 !== want[i]) begin
        tests_failed++;
        $display("FAIL lookup_a5[%0d]: out_valid=%b m1=%b, required 1 %b",
                 addr[i], out_valid, m1, want[i]);
      end
      step();
    end
  endtask

  task automatic test_stalled_load();
    done_seen = 0;
    pulse_start();
    send_beats(8'hA5, BEATS - 1, 1'b1);
    tests_run++;
    if (done_seen != 0) begin
      tests_failed++;
      $display("FAIL stall_early_done: done=%0d required 0", done_seen);
    end
    send_beats(8'hA5, 1, 1'b1);
    tests_run++;
    if (done_seen != 1 || loaded !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_done: done=%0d loaded=%b, required 1 1", done_seen, loaded);
    end
    sweep(8'hA5);
  endtask

  task automatic test_restart();
    done_seen = 0;
    err_seen  = 0;
    pulse_start();
    send_beats(8'h3C, 10, 1'b0);
    // Offer a beat together with the restart; it must be dropped.
    cfg_valid = 1'b1;
    cfg_data  = 8'h00;
    pulse_start();
    cfg_valid = 1'b0;
    send_beats(8'hFF, BEATS, 1'b0);
    tests_run++;
    if (err_seen != 1 || done_seen != 1) begin
      tests_failed++;
      $display("FAIL restart: err=%0d done=%0d, required 1 1", err_seen, done_seen);
    end
    sweep(8'hFF);
  endtask

  task automatic test_back_to_back();
    // Lookup issued in the same cycle as cfg_start completes from the old image.
    in_valid  = 1'b1;
    m0        = 8'd7;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || m1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_lookup: out_valid=%b m1=%b, required 1 1", out_valid, m1);
    end
    m0 = 8'd8;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || m1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_gating: out_valid=%b m1=%b, required 0 1", out_valid, m1);
    end
  endtask

  task automatic test_reset_mid_load();
    send_beats(8'h5A, 20, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    m0 = 8'd1;
    step();
    in_valid = 1'b0;
    tests_run++;
    if (loaded !== 1'b0 || cfg_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_load: loaded=%b ready=%b out_valid=%b, required 0 0 0",
               loaded, cfg_ready, out_valid);
    end
    send_beats(8'hFF, 3, 1'b0);
    done_seen = 0;
    pulse_start();
    send_beats(8'h00, BEATS, 1'b0);
    tests_run++;
    if (done_seen != 1) begin
      tests_failed++;
      $display("FAIL reload_done: done=%0d required 1", done_seen);
    end
    sweep(8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_data  = 8'h00;
    cfg_valid = 1'b0;
    m0        = 8'h00;
    in_valid  = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_gating();
    test_full_load();
    test_stalled_load();
    test_restart();
    test_back_to_back();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lut8_cfg_loader.md
LUT8_CFG_LOADER -- requirements
Module: lut8_cfg_loader

Interface
REQ-001 Parameter IN_BITS, default 8: lookup address width; table depth is 2^IN_BITS entries of 1 bit each.
REQ-002 Parameter CFG_W, default 8: configuration beat width; SHALL divide 2^IN_BITS, giving BEATS = 2^IN_BITS/CFG_W (32 at defaults).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port cfg_start, input, 1: single-cycle request to begin a table load.
REQ-006 Port cfg_data, input, CFG_W: configuration beat payload.
REQ-007 Port cfg_valid, input, 1: cfg_data is valid this cycle.
REQ-008 Port cfg_ready, output, 1: block accepts a beat this cycle.
REQ-009 Port cfg_done, output, 1: one-cycle pulse when the final beat has been written.
REQ-010 Port cfg_err, output, 1: one-cycle pulse when a load is restarted before completing.
REQ-011 Port loaded, output, 1: table holds a complete, valid image.
REQ-012 Port M0, input, IN_BITS: lookup address (unsigned, M0[IN_BITS-1] is MSB).
REQ-013 Port in_valid, input, 1: lookup request.
REQ-014 Port M1, output, 1: registered lookup result.
REQ-015 Port out_valid, output, 1: M1 is valid this cycle.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and READY, with IDLE entered on reset.
REQ-017 From IDLE or READY, cfg_start=1 SHALL move the FSM to LOAD, clear the beat counter to 0 and clear loaded to 0.
REQ-018 cfg_ready SHALL be 1 exactly when the state is LOAD.
REQ-019 A beat is accepted on a cycle where cfg_valid=1, cfg_ready=1 and cfg_start=0.
  - Accepted beat k writes cfg_data[i] into table entry k*CFG_W+i, for i in 0..CFG_W-1.
  - The beat counter then increments by 1.
REQ-020 Acceptance of beat BEATS-1 SHALL cause the following:
  - The state becomes READY on the next cycle.
  - loaded becomes 1 on the next cycle.
  - cfg_done is 1 for exactly that next cycle.
  - The beat counter wraps to 0.
REQ-021 cfg_start=1 while in LOAD SHALL have the following effects:
  - The beat counter resets to 0 and the state stays LOAD.
  - cfg_err pulses for one cycle.
  - Any cfg_valid in that same cycle is ignored.
  - Table entries already written are not cleared.
REQ-022 cfg_valid outside LOAD SHALL be ignored, with no table change and no error.
REQ-023 The block SHALL ignore cfg_valid deassertion gaps (stalls) in LOAD; the counter holds its value and no timeout applies.
REQ-024 In READY, in_valid=1 SHALL produce M1=table[M0] and out_valid=1 on the next cycle (latency 1).
  - Lookups are accepted back-to-back, one per cycle.
REQ-025 When not in READY, in_valid SHALL be ignored.
  - out_valid=0.
  - M1 holds its previous value.
REQ-026 out_valid SHALL be 0 on any cycle not preceded by an accepted lookup.
REQ-027 A lookup in progress when cfg_start arrives in READY SHALL still complete.
  - The lookup accepted in the cfg_start cycle produces out_valid on the next cycle, using the old table.
REQ-028 The table SHALL be implementable as distributed storage.
  - At most one write port (CFG_W bits) and one read port.

Reset
REQ-029 On rst=1 the following values SHALL be forced on the next edge:
  - state=IDLE and beat counter=0.
  - All table entries=0.
  - loaded=0, cfg_ready=0, cfg_done=0, cfg_err=0.
  - M1=0, out_valid=0.
REQ-030 rst SHALL override all other inputs, including during LOAD.
  - A partial image is discarded.
  - A fresh cfg_start is required afterwards.
REQ-031 Immediately after reset the block SHALL not raise cfg_done or cfg_err until new stimulus arrives.

Verification
REQ-032 Full load: the bench SHALL apply the following stimulus and check the response.
  - Stimulus: cfg_start, then 32 beats of 8'hA5 with no gaps.
  - Response: cfg_done pulses once in the cycle after beat 31, then loaded=1, cfg_ready=0.
  - Lookups: M0=0 gives M1=1, M0=1 gives M1=0, M0=2 gives M1=1, M0=255 gives M1=1, each with out_valid 1 cycle later.
REQ-033 Stalled load: the bench SHALL check the following.
  - Stimulus: 32 beats with cfg_valid low on every other cycle.
  - Response: identical final table to REQ-032, and cfg_done pulses after the 32nd accepted beat only.
REQ-034 Restart: the bench SHALL check the following.
  - Stimulus: cfg_start after 10 beats, then 32 beats of 8'hFF.
  - Response: cfg_err pulses once, cfg_done pulses once, and all 256 lookups return 1.
REQ-035 Reset mid-load: the bench SHALL check the following.
  - Stimulus: rst after 20 beats.
  - Response: loaded=0, cfg_ready=0, and in_valid gives out_valid=0.
  - After a fresh load of 8'h00, all lookups return 0.
REQ-036 Lookup gating and throughput: the bench SHALL check the following.
  - In IDLE, in_valid=1 gives out_valid=0.
  - In READY, 256 consecutive lookups M0=0..255 give 256 consecutive out_valid cycles with M1 matching the loaded image, 1-cycle latency.
